// File: rtl/ghost_motion_ctrl.sv
// Ghost position/direction sequencer: latches direction at tile boundaries, steps 1 px per STEP_DIV frame ticks.
// Latency: registered outputs, a step is visible one cycle after its frame_tick. Backpressure: enable=0 freezes all state.
// Optional catch detector and RESPAWN state under `define GHOST_CATCH_EN.
module ghost_motion_ctrl #(
    parameter int unsigned TILE_LOG2     = 4,
    parameter int unsigned STEP_DIV      = 2,
    parameter int unsigned DECIDE_WAIT   = 2,
    parameter logic [10:0] START_X       = 11'd320,
    parameter logic [9:0]  START_Y       = 10'd240,
    parameter logic [3:0]  START_DIR     = 4'b0010,
    parameter logic [10:0] X_MAX         = 11'd624,
    parameter logic [9:0]  Y_MAX         = 10'd464,
    parameter int unsigned HIT_RADIUS    = 8,
    parameter int unsigned RESPAWN_TICKS = 60
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        frame_tick,
    input  logic [3:0]  move_direction,
    input  logic [10:0] pacman_curr_pos_x,
    input  logic [9:0]  pacman_curr_pos_y,
    output logic [10:0] ghost_curr_pos_x,
    output logic [9:0]  ghost_curr_pos_y,
    output logic [3:0]  prev_direction,
    output logic        deciding,
    output logic        caught
);

    localparam logic [3:0] DIR_RIGHT = 4'b0001;
    localparam logic [3:0] DIR_UP    = 4'b0010;
    localparam logic [3:0] DIR_DOWN  = 4'b0100;
    localparam logic [3:0] DIR_LEFT  = 4'b1000;
    localparam logic [3:0] STEP_LAST = 4'(STEP_DIV - 1);
    localparam logic [2:0] WAIT_LAST = 3'(DECIDE_WAIT - 1);

`ifdef GHOST_CATCH_EN
    typedef enum logic [1:0] {IDLE, DECIDE, MOVE, RESPAWN} state_t;
    localparam logic [15:0] RSP_LAST = 16'(RESPAWN_TICKS - 1);
`else
    typedef enum logic [1:0] {IDLE, DECIDE, MOVE} state_t;
`endif

    state_t      state, state_nxt;
    logic [10:0] x_nxt, step_x;
    logic [9:0]  y_nxt, step_y;
    logic [3:0]  dir_nxt;
    logic [3:0]  step_cnt, step_nxt;
    logic [2:0]  wait_cnt, wait_nxt;
    logic        blocked;
    logic        step_aligned;
    logic        dir_onehot;
    logic        catch_hit;

`ifdef GHOST_CATCH_EN
    logic [15:0] rsp_cnt, rsp_nxt;
    logic        caught_nxt;
    logic [10:0] dx;
    logic [9:0]  dy;

    assign dx = (ghost_curr_pos_x >= pacman_curr_pos_x) ? ghost_curr_pos_x - pacman_curr_pos_x
                                                        : pacman_curr_pos_x - ghost_curr_pos_x;
    assign dy = (ghost_curr_pos_y >= pacman_curr_pos_y) ? ghost_curr_pos_y - pacman_curr_pos_y
                                                        : pacman_curr_pos_y - ghost_curr_pos_y;
    assign catch_hit = (dx <= 11'(HIT_RADIUS)) && (dy <= 10'(HIT_RADIUS));
`else
    logic unused_pacman;
    assign unused_pacman = ^{pacman_curr_pos_x, pacman_curr_pos_y};
    assign catch_hit     = 1'b0;
    assign caught        = 1'b0;
`endif

    assign dir_onehot   = (move_direction != 4'b0000) && ((move_direction & (move_direction - 4'd1)) == 4'b0000);
    assign step_aligned = (step_x[TILE_LOG2-1:0] == '0) && (step_y[TILE_LOG2-1:0] == '0);

    // Wall test happens on the current position, so the add/subtract never wraps.
    always_comb begin
        step_x  = ghost_curr_pos_x;
        step_y  = ghost_curr_pos_y;
        blocked = 1'b0;
        case (prev_direction)
            DIR_RIGHT: if (ghost_curr_pos_x >= X_MAX) blocked = 1'b1; else step_x = ghost_curr_pos_x + 11'd1;
            DIR_LEFT:  if (ghost_curr_pos_x == '0)    blocked = 1'b1; else step_x = ghost_curr_pos_x - 11'd1;
            DIR_DOWN:  if (ghost_curr_pos_y >= Y_MAX) blocked = 1'b1; else step_y = ghost_curr_pos_y + 10'd1;
            DIR_UP:    if (ghost_curr_pos_y == '0)    blocked = 1'b1; else step_y = ghost_curr_pos_y - 10'd1;
            default:   blocked = 1'b1;
        endcase
    end

    always_comb begin
        state_nxt = state;
        x_nxt     = ghost_curr_pos_x;
        y_nxt     = ghost_curr_pos_y;
        dir_nxt   = prev_direction;
        step_nxt  = step_cnt;
        wait_nxt  = wait_cnt;
`ifdef GHOST_CATCH_EN
        rsp_nxt    = rsp_cnt;
        caught_nxt = 1'b0;
`endif
        case (state)
            IDLE: begin
                state_nxt = DECIDE;
                wait_nxt  = '0;
            end
            DECIDE: begin
                if (catch_hit) begin
`ifdef GHOST_CATCH_EN
                    caught_nxt = 1'b1;
                    rsp_nxt    = '0;
                    wait_nxt   = '0;
                    state_nxt  = RESPAWN;
`endif
                end else if (wait_cnt == WAIT_LAST) begin
                    if (dir_onehot) dir_nxt = move_direction;
                    wait_nxt  = '0;
                    step_nxt  = '0;
                    state_nxt = MOVE;
                end else begin
                    wait_nxt = wait_cnt + 3'd1;
                end
            end
            MOVE: begin
                // A catch in the same cycle as a qualifying tick discards the step.
                if (catch_hit) begin
`ifdef GHOST_CATCH_EN
                    caught_nxt = 1'b1;
                    rsp_nxt    = '0;
                    state_nxt  = RESPAWN;
`endif
                end else if (frame_tick) begin
                    if (step_cnt == STEP_LAST) begin
                        step_nxt = '0;
                        if (blocked) begin
                            state_nxt = DECIDE;
                        end else begin
                            x_nxt = step_x;
                            y_nxt = step_y;
                            if (step_aligned) state_nxt = DECIDE;
                        end
                    end else begin
                        step_nxt = step_cnt + 4'd1;
                    end
                end
            end
`ifdef GHOST_CATCH_EN
            RESPAWN: begin
                if (frame_tick) begin
                    if (rsp_cnt == RSP_LAST) begin
                        rsp_nxt   = '0;
                        x_nxt     = START_X;
                        y_nxt     = START_Y;
                        dir_nxt   = START_DIR;
                        wait_nxt  = '0;
                        state_nxt = DECIDE;
                    end else begin
                        rsp_nxt = rsp_cnt + 16'd1;
                    end
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            ghost_curr_pos_x <= START_X;
            ghost_curr_pos_y <= START_Y;
            prev_direction   <= START_DIR;
            deciding         <= 1'b0;
            step_cnt         <= '0;
            wait_cnt         <= '0;
`ifdef GHOST_CATCH_EN
            caught           <= 1'b0;
            rsp_cnt          <= '0;
`endif
        end else if (enable) begin
            state            <= state_nxt;
            ghost_curr_pos_x <= x_nxt;
            ghost_curr_pos_y <= y_nxt;
            prev_direction   <= dir_nxt;
            deciding         <= (state_nxt == DECIDE);
            step_cnt         <= step_nxt;
            wait_cnt         <= wait_nxt;
`ifdef GHOST_CATCH_EN
            caught           <= caught_nxt;
            rsp_cnt          <= rsp_nxt;
`endif
        end
    end

endmodule
